// File: rtl/pdp_ram_mixed.sv
// Pseudo-dual-port frame RAM: narrow write port, wide read port, one clock.
// Optional output register and a sweep engine that zeroes the whole array.
module pdp_ram_mixed #(
    parameter int WR_ADDR_W  = 12,
    parameter int WR_DATA_W  = 2,
    parameter int RATIO_LOG2 = 1,
    parameter int OUT_REG    = 1,
    parameter int INIT_CLEAR = 1,
    localparam int RD_DATA_W = WR_DATA_W << RATIO_LOG2,
    localparam int RD_ADDR_W = WR_ADDR_W - RATIO_LOG2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [WR_ADDR_W-1:0] wr_addr,
    input  logic [WR_DATA_W-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [RD_ADDR_W-1:0] rd_addr,
    output logic [RD_DATA_W-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 clear_req,
    output logic                 busy
);

    localparam int R     = 1 << RATIO_LOG2;
    localparam int DEPTH = 1 << RD_ADDR_W;
    localparam logic [WR_ADDR_W-1:0] LANE_MASK = WR_ADDR_W'(R - 1);
    localparam logic [RD_DATA_W-1:0] BE0 = RD_DATA_W'({WR_DATA_W{1'b1}});

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam state_t RST_STATE = (INIT_CLEAR != 0) ? CLEAR : IDLE;

    state_t               state_q, state_d;
    logic [RD_ADDR_W-1:0] cnt_q, cnt_d;
    logic [RD_DATA_W-1:0] ram_q, ram_d;
    logic                 v1_q, v1_d;

    logic [RD_DATA_W-1:0] mem [DEPTH];

    logic                 wr_ok;
    logic                 rd_ok;
    logic [RD_ADDR_W-1:0] wr_row;
    logic [WR_ADDR_W-1:0] wr_lane;
    logic [RD_DATA_W-1:0] wr_be;
    logic [RD_DATA_W-1:0] wr_wide;

    assign busy    = (state_q == CLEAR);
    assign wr_ok   = wr_en & ~busy;
    assign rd_ok   = rd_en & ~busy;
    assign wr_row  = wr_addr[WR_ADDR_W-1:RATIO_LOG2];
    assign wr_lane = wr_addr & LANE_MASK;
    assign wr_be   = BE0 << (wr_lane * WR_ADDR_W'(WR_DATA_W));
    assign wr_wide = {R{wr_data}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (clear_req) state_d = CLEAR;
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array has no reset; the sweep is the only way its contents get zeroed.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else if (wr_ok) begin
            mem[wr_row] <= (mem[wr_row] & ~wr_be) | (wr_wide & wr_be);
        end
    end

    // Nonblocking read of the old word gives read-first on collisions.
    always_comb begin
        ram_d = ram_q;
        v1_d  = rd_ok;
        if (rd_ok) ram_d = mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            ram_q <= ram_d;
            v1_q  <= v1_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [RD_DATA_W-1:0] out_q, out_d;
        logic                 v2_q, v2_d;

        always_comb begin
            out_d = out_q;
            v2_d  = v1_q;
            if (v1_q) out_d = ram_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                out_q <= '0;
                v2_q  <= 1'b0;
            end else begin
                out_q <= out_d;
                v2_q  <= v2_d;
            end
        end

        assign rd_data  = out_q;
        assign rd_valid = v2_q;
    end else begin : g_noreg
        assign rd_data  = ram_q;
        assign rd_valid = v1_q;
    end

endmodule

// File: doc/pdp_ram_mixed.md
# pdp_ram_mixed

Parametrised pseudo-dual-port frame RAM: a narrow write port, a wide read port and one clock, with an optional output register and a built-in clear engine. Successor to the fixed 4K×2 / 2K×4 frame RAM. Sits between the pixel-data ingest path (write side) and the row-scan output path (read side). Also provides deterministic zero-initialisation after reset or on request.

## Interface
Parameters:
- WR_ADDR_W, 12, write address width; write depth = 2^WR_ADDR_W words.
- WR_DATA_W, 2, write word width in bits.
- RATIO_LOG2, 1, log2 of read/write width ratio R.
  - Read width RD_DATA_W = WR_DATA_W<<RATIO_LOG2.
  - Read address width RD_ADDR_W = WR_ADDR_W-RATIO_LOG2.
  - Legal range 0..3, and must be less than WR_ADDR_W.
- OUT_REG, 1, 1 adds an output pipeline register; 0 gives a single-stage read.
- INIT_CLEAR, 1, 1 runs the clear engine automatically out of reset.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  WR_ADDR_W  write address.
- wr_data  in  WR_DATA_W  write data.
- rd_en  in  1  read request.
- rd_addr  in  RD_ADDR_W  read address.
- rd_data  out  RD_DATA_W  read data.
- rd_valid  out  1  one-cycle pulse; rd_data is valid while it is high.
- clear_req  in  1  request a full-memory clear.
- busy  out  1  clear in progress; all port requests are ignored while high.

## Operation
- Packing: read word k holds write words k·R … k·R+R−1. The lowest write address occupies the LSBs.
- Write: when wr_en=1 and busy=0, wr_data is stored at wr_addr on the rising clk edge.
- Read: when rd_en=1 and busy=0, the read is accepted. Back-to-back reads are allowed at one per cycle.
- rd_data holds its last value when no read completes.
- Same-cycle collision (write to any sub-word of the word being read): read-first. rd_data returns the pre-write contents.
- Clear engine FSM:
  - States: IDLE and CLEAR.
  - IDLE→CLEAR when clear_req=1 while in IDLE.
  - In CLEAR, a counter walks read addresses 0 … 2^RD_ADDR_W−1, writing all zeros to one wide word per cycle.
  - After the last address the FSM returns to IDLE.
  - clear_req during CLEAR is ignored; there is no restart or extension.
- busy=1 exactly while the FSM is in CLEAR.
- wr_en and rd_en are dropped while busy=1: no write, no read, no rd_valid.
- Reads accepted before CLEAR is entered complete normally through the pipeline.
- Reset:
  - Reset values: FSM = CLEAR if INIT_CLEAR else IDLE; counter 0; busy = INIT_CLEAR; rd_data 0; rd_valid 0; pipeline registers 0.
  - Memory contents are not affected by reset_n; only the clear engine zeroes them.
  - Reset asserted mid-clear restarts the sweep from address 0 after release.

## Timing
- Read latency, from the rd_en edge to rd_valid/rd_data:
  - OUT_REG=0: 1 cycle (data registered at the RAM output).
  - OUT_REG=1: 2 cycles.
- A write is visible to reads accepted at the edge after the write edge or later.
- Clear duration: exactly 2^RD_ADDR_W cycles of busy=1 (2048 with defaults).
  - clear_req sampled high at edge n gives busy=1 from edge n through edge n+2047.
  - busy=0 after edge n+2048.
- With INIT_CLEAR=1, busy is high from reset assertion through the 2048th clk edge after release.
- rd_valid is never high for two cycles for a single request. It may be high on consecutive cycles for consecutive requests.

## Test plan
- Reset and init clear (defaults):
  - Stimulus: release reset_n.
  - Required: busy=1 for exactly 2048 cycles, then 0.
  - Required: reads of addresses 0, 1023 and 2047 return 4'b0000 with rd_valid two cycles after rd_en.
- Packing:
  - Stimulus: write wr_addr 12'hFFE←2'b01 and 12'hFFF←2'b10, then read rd_addr 11'h7FF.
  - Required: rd_data=4'b1001.
  - Stimulus: write 12'h000←2'b11, read 11'h000.
  - Required: rd_data=4'b0011.
- Collision:
  - Stimulus: in the same cycle, write 12'hFFF←2'b11 and read 11'h7FF, which previously held 4'b1001.
  - Required: that read returns 4'b1001; the next read returns 4'b1101.
- Streaming with OUT_REG=0 and OUT_REG=1:
  - Stimulus: 8 consecutive reads of distinct pre-written words.
  - Required: 8 consecutive rd_valid pulses at latency 1 and 2 respectively, with data in address order.
- Clear request:
  - Stimulus: pulse clear_req.
  - Required: busy for 2048 cycles; wr_en/rd_en during busy cause no write and no rd_valid.
  - Required: all sampled words read 0 afterwards.
  - Stimulus: a second clear_req mid-clear.
  - Required: duration unchanged.
- Reset mid-clear:
  - Stimulus: assert reset_n low at clear cycle 1000 for 3 cycles.
  - Required: rd_valid=0 and busy=1 (INIT_CLEAR=1) immediately.
  - Required: after release, a full 2048-cycle sweep.
